truth_table_sequencer: RTL and testbench
========================================

Name: truth_table_sequencer

Overview:
- Controller that exhaustively exercises a small combinational function block, such as a 3-input UDP equation.
- On a start request it walks every input combination in ascending binary order, waits a programmable settle time, and samples the block's 1-bit output.
- It builds the captured truth table and compares it against an expected table.
- It sits between a host/test controller and the function under test, and replaces hand-written vector lists.

Parameters:
- N_IN, 3, number of function inputs; table depth is 2**N_IN (legal range 1..6).
- SETTLE, 1, idle cycles between driving a vector and sampling it; 0 is legal.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep; honoured only in IDLE.
- abort  input  1  synchronous cancel of a running sweep.
- exp_table  input  2**N_IN  expected output; bit i is the expected output for input value i. Sampled per vector; must be held stable during a sweep.
- dut_out  input  1  output of the function under test.
- dut_in  output  N_IN  vector driven to the function; MSB maps to the first input (e.g. x of {x,y,z}).
- busy  output  1  high from the cycle after start is accepted until the return to IDLE.
- done  output  1  one-cycle pulse when a sweep completes; not asserted on abort.
- result_valid  output  1  table and compare results are valid.
- table_out  output  2**N_IN  captured truth table; bit i is dut_out sampled for dut_in == i.
- match  output  1  table_out == exp_table; meaningful only when result_valid is high.
- err_count  output  N_IN+1  number of mismatching entries.
- first_err_idx  output  N_IN  lowest mismatching index; 0 when there are no errors.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - dut_in, table_out, err_count and first_err_idx are 0.
  - busy, done, result_valid and match are 0.
- States: IDLE, WAIT, DONE. All outputs are registered.
- IDLE:
  - On start=1 at edge k: idx and dut_in go to 0, the settle counter loads SETTLE, and table_out, err_count and result_valid are cleared.
  - Next state is WAIT, and busy=1 from edge k.
- WAIT:
  - If abort=1: go to IDLE next edge. result_valid stays 0, done is not pulsed, dut_in returns to 0, and partial table_out is retained but invalid. Abort has priority over a same-cycle sample.
  - Else if counter != 0: decrement.
  - Else (sample cycle):
    - table_out[idx] <= dut_out.
    - If dut_out != exp_table[idx], increment err_count; on the first such mismatch only, capture first_err_idx <= idx.
    - If idx == 2**N_IN-1, go to DONE.
    - Otherwise idx++, dut_in <= idx+1, and the counter reloads SETTLE.
- Timing: vector i is sampled at edge k+(SETTLE+1)*(i+1), so the last sample is at edge k+(SETTLE+1)*2**N_IN.
- DONE:
  - Lasts one cycle: done=1, result_valid=1, and match = (err_count == 0), with err_count including the final sample.
  - busy stays 1, dut_in is held at all-ones.
  - Next edge goes to IDLE with busy=0 and dut_in=0.
- Results (table_out, match, err_count, first_err_idx, result_valid) hold in IDLE until the next accepted start.
- start while busy is ignored; abort in IDLE or DONE is ignored.
- start held high continuously re-launches a sweep on the IDLE cycle after each DONE.
- err_count cannot overflow: its maximum is 2**N_IN, which fits in N_IN+1 bits.
- Reset asserted mid-sweep clears everything immediately, without waiting for a clock edge.

Decomposition:
- Shared package tt_seq_pkg holds the state encoding localparams (IDLE=2'd0, WAIT=2'd1, DONE=2'd2) and a depth function (1<<N_IN).
- Natural sub-module: tt_settle_timer. It is a loadable down-counter with a load input, a load value of SETTLE, and a zero flag, and is reused by any future multi-cycle vector driver.
- Index, table capture and compare logic stay in the top module.

Test Plan:
- XOR function (dut_out = ^dut_in), N_IN=3, SETTLE=1, exp_table=8'h96, start pulse at edge k:
  - dut_in steps 0..7 every 2 cycles, done pulses at edge k+16, returning to IDLE at edge k+17.
  - Required results: table_out=8'h96, match=1, err_count=0, first_err_idx=0.
- dut_out tied to 0, exp_table=8'h96 → table_out=8'h00, match=0, err_count=4, first_err_idx=1, result_valid=1.
- SETTLE=0, dut_out = dut_in[2]&dut_in[1] (the x&y function), exp_table=8'hC0 → done at edge k+8, table_out=8'hC0, match=1.
- abort asserted while dut_in=3 → busy drops on the next edge, no done pulse, result_valid=0, dut_in=0.
  - A subsequent start then completes a full sweep normally.
- start re-pulsed mid-sweep has no effect: sweep timing is unchanged.
  - rst_n pulsed low mid-sweep, asynchronously (between clock edges) → all outputs go to 0 immediately.

Source files
------------

// File: rtl/tt_seq_pkg.sv
// tt_seq_pkg
//   Shared definitions for the truth-table sequencer and its helpers:
//   the controller state encoding and the table-depth helper.
package tt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } tt_state_e;

  // Number of entries in a truth table for n function inputs.
  function automatic int unsigned depth(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer
//   Loadable down-counter used to space out vector drive and sample.
//   load_i reloads LOAD_VAL; dec_i counts down and stops at zero.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset (count clears to 0)
//     load_i - reload the count with LOAD_VAL (wins over dec_i)
//     dec_i  - decrement by one while non-zero
//     zero_o - count is zero
module tt_settle_timer #(
  parameter int unsigned LOAD_VAL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int unsigned CNT_W = (LOAD_VAL > 0) ? $clog2(LOAD_VAL + 1) : 1;
  localparam logic [CNT_W-1:0] LOAD_Q = CNT_W'(LOAD_VAL);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_Q;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer
//   Walks every input combination of a small combinational block in
//   ascending order, waits SETTLE cycles per vector, samples the block's
//   output into a truth table and compares it with an expected table.
//   Ports:
//     clk, rst_n    - clock / asynchronous active-low reset
//     start         - launch a sweep (only from IDLE)
//     abort         - cancel a running sweep
//     exp_table     - expected table, bit i for input value i
//     dut_out       - output of the function under test
//     dut_in        - vector driven to the function (MSB = first input)
//     busy          - sweep in progress (including the DONE cycle)
//     done          - one-cycle completion pulse
//     result_valid  - table/compare outputs are valid
//     table_out     - captured table, bit i sampled with dut_in == i
//     match         - captured table equals expected table
//     err_count     - number of mismatching entries
//     first_err_idx - lowest mismatching index (0 if none)
module truth_table_sequencer
  import tt_seq_pkg::*;
#(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [depth(N_IN)-1:0]  exp_table,
  input  logic                    dut_out,
  output logic [N_IN-1:0]         dut_in,
  output logic                    busy,
  output logic                    done,
  output logic                    result_valid,
  output logic [depth(N_IN)-1:0]  table_out,
  output logic                    match,
  output logic [N_IN:0]           err_count,
  output logic [N_IN-1:0]         first_err_idx
);

  localparam int unsigned   DEPTH    = depth(N_IN);
  localparam logic [N_IN-1:0] LAST_IDX = '1;

  tt_state_e            state_q, state_d;
  logic [N_IN-1:0]      idx_q, idx_d;
  logic [N_IN-1:0]      dut_in_q, dut_in_d;
  logic [DEPTH-1:0]     table_q, table_d;
  logic [N_IN:0]        err_q, err_d;
  logic [N_IN-1:0]      first_q, first_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 valid_q, valid_d;
  logic                 match_q, match_d;

  logic                 timer_load;
  logic                 timer_dec;
  logic                 timer_zero;

  tt_settle_timer #(
    .LOAD_VAL (SETTLE)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (timer_load),
    .dec_i  (timer_dec),
    .zero_o (timer_zero)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dut_in_d   = dut_in_q;
    table_d    = table_q;
    err_d      = err_q;
    first_d    = first_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    valid_d    = valid_q;
    match_d    = match_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = WAIT;
          busy_d     = 1'b1;
          idx_d      = '0;
          dut_in_d   = '0;
          timer_load = 1'b1;
          table_d    = '0;
          err_d      = '0;
          first_d    = '0;
          valid_d    = 1'b0;
          match_d    = 1'b0;
        end
      end

      WAIT: begin
        if (abort) begin
          // Partial table is kept for debug but never marked valid.
          state_d  = IDLE;
          busy_d   = 1'b0;
          dut_in_d = '0;
        end else if (!timer_zero) begin
          timer_dec = 1'b1;
        end else begin
          table_d[idx_q] = dut_out;
          if (dut_out != exp_table[idx_q]) begin
            err_d = err_q + 1'b1;
            // A zero count before this sample means this is the first miss.
            if (err_q == '0) begin
              first_d = idx_q;
            end
          end
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            done_d  = 1'b1;
            valid_d = 1'b1;
            match_d = (err_d == '0);
          end else begin
            idx_d      = idx_q + 1'b1;
            dut_in_d   = idx_q + 1'b1;
            timer_load = 1'b1;
          end
        end
      end

      DONE: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        dut_in_d = '0;
      end

      default: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        dut_in_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      dut_in_q <= '0;
      table_q  <= '0;
      err_q    <= '0;
      first_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dut_in_q <= dut_in_d;
      table_q  <= table_d;
      err_q    <= err_d;
      first_q  <= first_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      match_q  <= match_d;
    end
  end

  assign dut_in        = dut_in_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign result_valid  = valid_q;
  assign table_out     = table_q;
  assign match         = match_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: instance A (N_IN=3, SETTLE=1) and
// instance B (N_IN=3, SETTLE=0), each driving a behavioural function.
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;

  logic       start_a, abort_a, dout_a;
  logic [7:0] exp_a;
  logic [2:0] din_a;
  logic       busy_a, done_a, rv_a, match_a;
  logic [7:0] tbl_a;
  logic [3:0] err_a;
  logic [2:0] fe_a;

  logic       start_b, abort_b, dout_b;
  logic [7:0] exp_b;
  logic [2:0] din_b;
  logic       busy_b, done_b, rv_b, match_b;
  logic [7:0] tbl_b;
  logic [3:0] err_b;
  logic [2:0] fe_b;

  int sel_a = 0;
  int sel_b = 2;
  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] tbl;
    logic [3:0] err;
    logic [2:0] first;
    logic       match;
    int         done_cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  truth_table_sequencer #(.N_IN(3), .SETTLE(1)) u_dut_a (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start_a),
    .abort         (abort_a),
    .exp_table     (exp_a),
    .dut_out       (dout_a),
    .dut_in        (din_a),
    .busy          (busy_a),
    .done          (done_a),
    .result_valid  (rv_a),
    .table_out     (tbl_a),
    .match         (match_a),
    .err_count     (err_a),
    .first_err_idx (fe_a)
  );

  truth_table_sequencer #(.N_IN(3), .SETTLE(0)) u_dut_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start_b),
    .abort         (abort_b),
    .exp_table     (exp_b),
    .dut_out       (dout_b),
    .dut_in        (din_b),
    .busy          (busy_b),
    .done          (done_b),
    .result_valid  (rv_b),
    .table_out     (tbl_b),
    .match         (match_b),
    .err_count     (err_b),
    .first_err_idx (fe_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Functions under test: 0 = x^y^z, 1 = constant 0, 2 = x&y.
  function automatic logic fn(input int sel, input logic [2:0] v);
    case (sel)
      0:       return ^v;
      2:       return v[2] & v[1];
      default: return 1'b0;
    endcase
  endfunction

  always_comb dout_a = fn(sel_a, din_a);
  always_comb dout_b = fn(sel_b, din_b);

  function automatic exp_t model(input int sel, input logic [7:0] expt, input int dc);
    exp_t       e;
    logic [7:0] d;
    e.tbl   = 8'h00;
    e.err   = 4'd0;
    e.first = 3'd0;
    for (int i = 0; i < 8; i++) e.tbl[i] = fn(sel, 3'(i));
    d = e.tbl ^ expt;
    for (int i = 7; i >= 0; i--) begin
      if (d[i]) begin
        e.err   = e.err + 4'd1;
        e.first = 3'(i);
      end
    end
    e.match    = (d == 8'h00);
    e.done_cyc = dc;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n === 1'b1 && done_a === 1'b1) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_done", 32'(done_a), 32'd0);
      end else begin
        e = q_a.pop_front();
        chk("a_done_cycle", 32'(cyc),     32'(e.done_cyc));
        chk("a_table",      32'(tbl_a),   32'(e.tbl));
        chk("a_err_count",  32'(err_a),   32'(e.err));
        chk("a_first_err",  32'(fe_a),    32'(e.first));
        chk("a_match",      32'(match_a), 32'(e.match));
        chk("a_valid",      32'(rv_a),    32'd1);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n === 1'b1 && done_b === 1'b1) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_done", 32'(done_b), 32'd0);
      end else begin
        e = q_b.pop_front();
        chk("b_done_cycle", 32'(cyc),     32'(e.done_cyc));
        chk("b_table",      32'(tbl_b),   32'(e.tbl));
        chk("b_err_count",  32'(err_b),   32'(e.err));
        chk("b_first_err",  32'(fe_b),    32'(e.first));
        chk("b_match",      32'(match_b), 32'(e.match));
        chk("b_valid",      32'(rv_b),    32'd1);
      end
    end
  end

  task automatic sweep_a(input int sel, input logic [7:0] expt, input bit repulse);
    int k;
    sel_a = sel;
    exp_a = expt;
    @(posedge clk); #1;
    start_a = 1'b1;
    k = cyc + 1;
    q_a.push_back(model(sel, expt, k + 16));
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("a_valid_cleared", 32'(rv_a), 32'd0);
    for (int c = 0; c < 16; c++) begin
      chk("a_dut_in", 32'(din_a), 32'(c / 2));
      chk("a_busy",   32'(busy_a), 32'd1);
      start_a = (repulse && c == 5);
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    chk("a_done_vec",  32'(din_a),  32'd7);
    chk("a_done_busy", 32'(busy_a), 32'd1);
    @(posedge clk); #1;
    chk("a_idle_busy",  32'(busy_a), 32'd0);
    chk("a_idle_din",   32'(din_a),  32'd0);
    chk("a_idle_done",  32'(done_a), 32'd0);
    chk("a_idle_valid", 32'(rv_a),   32'd1);
  endtask

  task automatic sweep_b(input logic [7:0] expt);
    int k;
    exp_b = expt;
    @(posedge clk); #1;
    start_b = 1'b1;
    k = cyc + 1;
    q_b.push_back(model(sel_b, expt, k + 8));
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("b_dut_in", 32'(din_b), 32'(c));
      @(posedge clk); #1;
    end
    chk("b_done_pulse", 32'(done_b), 32'd1);
    @(posedge clk); #1;
    chk("b_idle_busy", 32'(busy_b), 32'd0);
    chk("b_idle_din",  32'(din_b),  32'd0);
  endtask

  task automatic abort_a_at3();
    int n;
    sel_a = 0;
    exp_a = 8'h96;
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    n = 0;
    while (din_a !== 3'd3 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_reach_vec3", 32'(din_a), 32'd3);
    // Second cycle on vector 3 is its sample cycle: abort must win.
    @(posedge clk); #1;
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    chk("abort_busy",    32'(busy_a), 32'd0);
    chk("abort_din",     32'(din_a),  32'd0);
    chk("abort_valid",   32'(rv_a),   32'd0);
    chk("abort_done",    32'(done_a), 32'd0);
    chk("abort_partial", 32'(tbl_a),  32'h06);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_stays_idle", 32'(busy_a), 32'd0);
  endtask

  task automatic reset_mid_sweep();
    sel_a = 0;
    exp_a = 8'h96;
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_busy",  32'(busy_a),  32'd0);
    chk("rst_din",   32'(din_a),   32'd0);
    chk("rst_table", 32'(tbl_a),   32'd0);
    chk("rst_err",   32'(err_a),   32'd0);
    chk("rst_first", 32'(fe_a),    32'd0);
    chk("rst_valid", 32'(rv_a),    32'd0);
    chk("rst_match", 32'(match_a), 32'd0);
    chk("rst_b_tbl", 32'(tbl_b),   32'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_after_busy", 32'(busy_a), 32'd0);
  endtask

  task automatic held_start();
    int k;
    sel_a = 0;
    exp_a = 8'h96;
    @(posedge clk); #1;
    start_a = 1'b1;
    k = cyc + 1;
    q_a.push_back(model(0, 8'h96, k + 16));
    q_a.push_back(model(0, 8'h96, k + 34));
    repeat (35) @(posedge clk);
    #1;
    start_a = 1'b0;
    chk("held_second_done", 32'(done_a), 32'd1);
    @(posedge clk); #1;
    chk("held_idle", 32'(busy_a), 32'd0);
    @(posedge clk); #1;
    chk("held_no_relaunch", 32'(busy_a), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; exp_a = 8'h00;
    start_b = 1'b0; abort_b = 1'b0; exp_b = 8'h00;
    #12;
    chk("por_busy",  32'(busy_a), 32'd0);
    chk("por_din",   32'(din_a),  32'd0);
    chk("por_table", 32'(tbl_a),  32'd0);
    chk("por_valid", 32'(rv_a),   32'd0);
    chk("por_done",  32'(done_a), 32'd0);
    rst_n = 1'b1;

    sweep_a(0, 8'h96, 1'b0);   // XOR, all match
    sweep_a(1, 8'h96, 1'b0);   // stuck-at-0: 4 errors, first at 1
    sweep_b(8'hC0);            // x&y with no settle time
    abort_a_at3();
    sweep_a(0, 8'h96, 1'b0);   // clean sweep after abort
    sweep_a(0, 8'h97, 1'b1);   // start re-pulse mid-sweep, one miss at 0
    reset_mid_sweep();
    held_start();
    sweep_a(2, 8'h96, 1'b0);   // x&y against XOR table: errors at 1,2,4,6

    repeat (3) @(posedge clk);
    #1;
    chk("a_pending", 32'(q_a.size()), 32'd0);
    chk("b_pending", 32'(q_b.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
